// File: rtl/nubus_mem_arbiter.sv
// rtl/nubus_mem_arbiter.sv - two-port (NuBus slave / local CPU) arbiter for the card's local memory port
// Optional access timeout enabled by defining NUBUS_MEM_ARB_TIMEOUT_EN.
module nubus_mem_arbiter #(
    parameter int FAIR    = 1,
    parameter int TIMEOUT = 255,
    parameter int TW      = 16
) (
    input  logic        nub_clk,
    input  logic        nub_reset,
    input  logic        s_valid,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_ready,
    output logic [31:0] s_rdata,
    output logic        s_err,
    input  logic        c_valid,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_wstrb,
    input  logic        c_lock,
    output logic        c_ready,
    output logic [31:0] c_rdata,
    output logic        c_err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant_o
);

    typedef enum logic [2:0] {IDLE, S_ACC, C_ACC, C_LOCK, DONE} state_t;

    state_t state, state_nx;
    logic   prefer_cpu, prefer_cpu_nx;
    logic   owner_cpu;
    logic   grant_s, grant_c;
    logic   finish, expire;
    logic   expire_hit;
    logic   is_read;
    logic [1:0] grant_nx;

    if (TIMEOUT < 1 || TIMEOUT > 65535 || (64'(TIMEOUT) >> TW) != 0) begin : g_bad_cfg
        $error("nubus_mem_arbiter: TIMEOUT out of range or wider than TW");
    end

    assign is_read = (mem_wstrb == 4'b0000);

    always_comb begin
        state_nx      = state;
        prefer_cpu_nx = prefer_cpu;
        grant_s       = 1'b0;
        grant_c       = 1'b0;
        finish        = 1'b0;
        expire        = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid && (!c_valid || FAIR == 0 || !prefer_cpu))
                    grant_s = 1'b1;
                else if (c_valid)
                    grant_c = 1'b1;
            end
            S_ACC, C_ACC: begin
                // mem_ready on the expiry edge wins over the timeout
                if (mem_ready) begin
                    finish = 1'b1;
                end else if (expire_hit) begin
                    finish = 1'b1;
                    expire = 1'b1;
                end
            end
            C_LOCK: begin
                if (c_valid) begin
                    grant_c = 1'b1;
                end else if (!c_lock) begin
                    state_nx      = IDLE;
                    prefer_cpu_nx = 1'b0;
                end
            end
            DONE: state_nx = (owner_cpu && c_lock) ? C_LOCK : IDLE;
            default: state_nx = IDLE;
        endcase
        if (grant_s) begin
            state_nx      = S_ACC;
            prefer_cpu_nx = 1'b1;
        end
        if (grant_c) begin
            state_nx      = C_ACC;
            prefer_cpu_nx = 1'b0;
        end
        if (finish)
            state_nx = DONE;
    end

    always_comb begin
        grant_nx = 2'b00;
        case (state_nx)
            S_ACC:         grant_nx = 2'b01;
            C_ACC, C_LOCK: grant_nx = 2'b10;
            default:       grant_nx = 2'b00;
        endcase
    end

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state      <= IDLE;
            prefer_cpu <= 1'b0;
            owner_cpu  <= 1'b0;
            grant_o    <= 2'b00;
            mem_valid  <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wstrb  <= 4'h0;
            s_ready    <= 1'b0;
            s_rdata    <= 32'h0;
            s_err      <= 1'b0;
            c_ready    <= 1'b0;
            c_rdata    <= 32'h0;
            c_err      <= 1'b0;
        end else begin
            state      <= state_nx;
            prefer_cpu <= prefer_cpu_nx;
            grant_o    <= grant_nx;
            s_ready    <= 1'b0;
            s_err      <= 1'b0;
            c_ready    <= 1'b0;
            c_err      <= 1'b0;
            if (grant_s) begin
                owner_cpu <= 1'b0;
                mem_valid <= 1'b1;
                mem_addr  <= s_addr;
                mem_wdata <= s_wdata;
                mem_wstrb <= s_wstrb;
            end
            if (grant_c) begin
                owner_cpu <= 1'b1;
                mem_valid <= 1'b1;
                mem_addr  <= c_addr;
                mem_wdata <= c_wdata;
                mem_wstrb <= c_wstrb;
            end
            if (finish) begin
                mem_valid <= 1'b0;
                if (owner_cpu) begin
                    c_ready <= 1'b1;
                    c_err   <= expire;
                    if (expire)
                        c_rdata <= 32'hFFFF_FFFF;
                    else if (is_read)
                        c_rdata <= mem_rdata;
                end else begin
                    s_ready <= 1'b1;
                    s_err   <= expire;
                    if (expire)
                        s_rdata <= 32'hFFFF_FFFF;
                    else if (is_read)
                        s_rdata <= mem_rdata;
                end
            end
        end
    end

`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;

    assign expire_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset)
            tmo_cnt <= '0;
        else if (grant_s || grant_c)
            tmo_cnt <= '0;
        else if (state == S_ACC || state == C_ACC)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign expire_hit = 1'b0;
`endif

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// tb/tb_nubus_mem_arbiter.sv - scoreboard bench for nubus_mem_arbiter (FAIR=1, TIMEOUT=4)
module tb_nubus_mem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } gexp_t;

    logic        nub_clk = 1'b0;
    logic        nub_reset = 1'b1;
    logic        s_valid = 1'b0, c_valid = 1'b0, c_lock = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0, c_addr = '0, c_wdata = '0;
    logic [3:0]  s_wstrb = '0, c_wstrb = '0;
    logic        s_ready, s_err, c_ready, c_err, mem_valid;
    logic [31:0] s_rdata, c_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  grant_o;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic [138:0] all_out;

    int    checks = 0, errors = 0;
    int    mem_lat = 1;
    bit    mem_en = 1'b1;
    logic [31:0] s_last = '0, c_last = '0;
    resp_t exp_s_q[$], exp_c_q[$];
    gexp_t exp_g_q[$];

    nubus_mem_arbiter #(.FAIR(1), .TIMEOUT(4), .TW(16)) dut (
        .nub_clk(nub_clk), .nub_reset(nub_reset),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata), .s_err(s_err),
        .c_valid(c_valid), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
        .c_lock(c_lock), .c_ready(c_ready), .c_rdata(c_rdata), .c_err(c_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_o(grant_o)
    );

    assign all_out = {s_ready, s_rdata, s_err, c_ready, c_rdata, c_err,
                      mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_o};

    always #5 nub_clk = ~nub_clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'hF900_0010)
            return 32'h1234_5678;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // memory responder: mem_ready after mem_lat cycles of mem_valid
    initial begin
        int lat_cnt;
        lat_cnt = 0;
        forever begin
            @(posedge nub_clk);
            #1;
            if (mem_ready || !mem_valid || !mem_en) begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
                lat_cnt   = 0;
            end else begin
                lat_cnt++;
                if (lat_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                end
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic  mv_q, sr_q, cr_q;
        resp_t r;
        gexp_t g;
        mv_q = 0; sr_q = 0; cr_q = 0;
        forever begin
            @(negedge nub_clk);
            if (s_ready) begin
                checks++;
                if (exp_s_q.size() == 0) begin
                    errors++;
                    $display("FAIL s_resp_unexpected: s_ready=1 with no request outstanding");
                end else begin
                    r = exp_s_q.pop_front();
                    if (s_rdata !== r.rdata || s_err !== r.err) begin
                        errors++;
                        $display("FAIL s_resp: rdata=%h err=%b expected rdata=%h err=%b", s_rdata, s_err, r.rdata, r.err);
                    end
                end
                checks++;
                if (sr_q || c_ready) begin
                    errors++;
                    $display("FAIL s_ready_pulse: prev=%b c_ready=%b expected 0/0", sr_q, c_ready);
                end
            end
            if (c_ready) begin
                checks++;
                if (exp_c_q.size() == 0) begin
                    errors++;
                    $display("FAIL c_resp_unexpected: c_ready=1 with no request outstanding");
                end else begin
                    r = exp_c_q.pop_front();
                    if (c_rdata !== r.rdata || c_err !== r.err) begin
                        errors++;
                        $display("FAIL c_resp: rdata=%h err=%b expected rdata=%h err=%b", c_rdata, c_err, r.rdata, r.err);
                    end
                end
                checks++;
                if (cr_q) begin
                    errors++;
                    $display("FAIL c_ready_pulse: c_ready high two cycles, expected one");
                end
            end
            if (mem_valid && !mv_q) begin
                checks++;
                if (exp_g_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: grant_o=%b addr=%h", grant_o, mem_addr);
                end else begin
                    g = exp_g_q.pop_front();
                    if (grant_o !== g.grant || mem_addr !== g.addr || mem_wdata !== g.wdata || mem_wstrb !== g.wstrb) begin
                        errors++;
                        $display("FAIL grant: grant=%b addr=%h wdata=%h wstrb=%h expected grant=%b addr=%h wdata=%h wstrb=%h",
                                 grant_o, mem_addr, mem_wdata, mem_wstrb, g.grant, g.addr, g.wdata, g.wstrb);
                    end
                end
            end
            mv_q = mem_valid;
            sr_q = s_ready;
            cr_q = c_ready;
        end
    end

    function automatic gexp_t mk_g(input logic [1:0] gr, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] st);
        gexp_t g;
        g.grant = gr; g.addr = a; g.wdata = d; g.wstrb = st;
        return g;
    endfunction

    // call at a negedge; returns at the negedge where s_ready is seen
    task automatic s_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                         input bit drop_early, output int cycles);
        resp_t r;
        if (st == 4'h0)
            s_last = mem_model(a);
        r.rdata = s_last; r.err = 1'b0;
        exp_s_q.push_back(r);
        s_valid = 1'b1; s_addr = a; s_wdata = d; s_wstrb = st;
        cycles = 0;
        while (cycles < 200) begin
            @(negedge nub_clk);
            cycles++;
            if (drop_early)
                s_valid = 1'b0;
            if (s_ready)
                break;
        end
        s_valid = 1'b0;
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL s_req_wait: s_ready=%b after %0d cycles, expected 1", s_ready, cycles);
        end
        checks++;
        if (grant_o !== 2'b00 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL s_done_state: grant_o=%b mem_valid=%b expected 00/0", grant_o, mem_valid);
        end
    endtask

    task automatic c_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                         input bit exp_timeout, output int cycles);
        resp_t r;
        if (exp_timeout)
            c_last = 32'hFFFF_FFFF;
        else if (st == 4'h0)
            c_last = mem_model(a);
        r.rdata = c_last; r.err = exp_timeout;
        exp_c_q.push_back(r);
        c_valid = 1'b1; c_addr = a; c_wdata = d; c_wstrb = st;
        cycles = 0;
        while (cycles < 200) begin
            @(negedge nub_clk);
            cycles++;
            if (c_ready)
                break;
        end
        c_valid = 1'b0;
        checks++;
        if (!c_ready) begin
            errors++;
            $display("FAIL c_req_wait: c_ready=%b after %0d cycles, expected 1", c_ready, cycles);
        end
        checks++;
        if (grant_o !== 2'b00 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL c_done_state: grant_o=%b mem_valid=%b expected 00/0", grant_o, mem_valid);
        end
    endtask

    task automatic test_reset;
        int cyc;
        @(negedge nub_clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_init: outputs=%h expected 0", all_out);
        end
        nub_reset = 1'b0;
        mem_en = 1'b0;
        exp_g_q.push_back(mk_g(2'b01, 32'hF900_0100, 32'h0, 4'h0));
        @(negedge nub_clk);
        s_valid = 1'b1; s_addr = 32'hF900_0100; s_wdata = '0; s_wstrb = '0;
        repeat (3) @(negedge nub_clk);
        checks++;
        if (grant_o !== 2'b01 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_access: grant_o=%b mem_valid=%b expected 01/1", grant_o, mem_valid);
        end
        nub_reset = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_access: outputs=%h expected 0", all_out);
        end
        s_valid = 1'b0;
        @(negedge nub_clk);
        nub_reset = 1'b0;
        mem_en = 1'b1;
        mem_lat = 1;
        s_last = '0; c_last = '0;
        repeat (3) @(negedge nub_clk);
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_after: outputs=%h expected 0", all_out);
        end
        exp_g_q.push_back(mk_g(2'b01, 32'hF900_0200, 32'h0, 4'h0));
        s_req(32'hF900_0200, 32'h0, 4'h0, 1'b0, cyc);
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL reset_regrant_latency: %0d cycles expected 2", cyc);
        end
    endtask

    task automatic test_slave_read;
        int cyc;
        mem_lat = 2;
        @(negedge nub_clk);
        exp_g_q.push_back(mk_g(2'b01, 32'hF900_0010, 32'h0, 4'h0));
        s_req(32'hF900_0010, 32'h0, 4'h0, 1'b0, cyc);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL slave_read_latency: %0d cycles expected 3", cyc);
        end
        mem_lat = 1;
    endtask

    task automatic test_cpu_rw;
        int cyc;
        @(negedge nub_clk);
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_0040, 32'h0, 4'h0));
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_0044, 32'hA1B2_C3D4, 4'h3));
        c_req(32'h0000_0040, 32'h0, 4'h0, 1'b0, cyc);
        c_req(32'h0000_0044, 32'hA1B2_C3D4, 4'h3, 1'b0, cyc);
    endtask

    task automatic test_fair;
        int cyc_s, cyc_c;
        @(negedge nub_clk);
        exp_g_q.push_back(mk_g(2'b01, 32'h0000_0300, 32'h0, 4'h0));
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_0304, 32'h0, 4'h0));
        exp_g_q.push_back(mk_g(2'b01, 32'h0000_0308, 32'h0, 4'h0));
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_030C, 32'h0, 4'h0));
        fork
            begin
                s_req(32'h0000_0300, 32'h0, 4'h0, 1'b0, cyc_s);
                s_req(32'h0000_0308, 32'h0, 4'h0, 1'b0, cyc_s);
            end
            begin
                c_req(32'h0000_0304, 32'h0, 4'h0, 1'b0, cyc_c);
                c_req(32'h0000_030C, 32'h0, 4'h0, 1'b0, cyc_c);
            end
        join
    endtask

    task automatic test_lock;
        int cyc_s, cyc_c;
        @(negedge nub_clk);
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_0100, 32'hCAFE_0001, 4'hF));
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_0104, 32'h0, 4'h0));
        exp_g_q.push_back(mk_g(2'b01, 32'h0000_0200, 32'h0, 4'h0));
        c_lock = 1'b1;
        c_req(32'h0000_0100, 32'hCAFE_0001, 4'hF, 1'b0, cyc_c);
        fork
            s_req(32'h0000_0200, 32'h0, 4'h0, 1'b0, cyc_s);
            begin
                repeat (2) @(negedge nub_clk);
                checks++;
                if (grant_o !== 2'b10 || mem_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_hold: grant_o=%b mem_valid=%b expected 10/0", grant_o, mem_valid);
                end
                c_req(32'h0000_0104, 32'h0, 4'h0, 1'b0, cyc_c);
                repeat (3) @(negedge nub_clk);
                checks++;
                if (grant_o !== 2'b10 || mem_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_hold2: grant_o=%b mem_valid=%b expected 10/0", grant_o, mem_valid);
                end
                c_lock = 1'b0;
            end
        join
    endtask

    task automatic test_drop;
        int cyc;
        @(negedge nub_clk);
        exp_g_q.push_back(mk_g(2'b01, 32'h0000_0500, 32'h0, 4'h0));
        mem_lat = 3;
        s_req(32'h0000_0500, 32'h0, 4'h0, 1'b1, cyc);
        mem_lat = 1;
    endtask

`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int cyc;
        @(negedge nub_clk);
        mem_en = 1'b0;
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_0400, 32'h0, 4'h0));
        c_req(32'h0000_0400, 32'h0, 4'h0, 1'b1, cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles expected 5", cyc);
        end
        mem_en = 1'b1;
    endtask

    task automatic test_timeout_edge;
        int cyc;
        @(negedge nub_clk);
        mem_lat = 4;
        exp_g_q.push_back(mk_g(2'b10, 32'h0000_0404, 32'h0, 4'h0));
        c_req(32'h0000_0404, 32'h0, 4'h0, 1'b0, cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL timeout_edge_latency: %0d cycles expected 5", cyc);
        end
        mem_lat = 1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_slave_read();
        test_cpu_rw();
        test_fair();
        test_lock();
        test_drop();
`ifdef NUBUS_MEM_ARB_TIMEOUT_EN
        test_timeout();
        test_timeout_edge();
`endif
        repeat (4) @(negedge nub_clk);
        checks++;
        if (exp_s_q.size() != 0 || exp_c_q.size() != 0 || exp_g_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: s=%0d c=%0d g=%0d expected 0/0/0",
                     exp_s_q.size(), exp_c_q.size(), exp_g_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
